linear_output_packer: RTL and testbench
=======================================

Name: linear_output_packer

Overview:
- Downstream stage of the parallel-feature multiplier/output-stage pipeline.
- Collects the NUM_FEATURES quantised PRECISION-bit results produced per valid beat and packs them into OUT_LANES-wide words.
- Buffers the packed words in a FIFO and presents them on a valid/ready stream to the output memory writer.
- Drives in_ready, which upstream uses as its pipeline clock-enable, with slack for results already in flight.

Parameters:
- PRECISION, 8, bit width of one result lane.
- NUM_FEATURES, 2, results delivered per input beat.
- OUT_LANES, 8, lanes per output word. Must be a multiple of NUM_FEATURES.
- FIFO_DEPTH, 16, number of packed words buffered. Power of two, at least 4.
- PIPE_SLACK, 4, upstream pipeline depth still in flight after in_ready falls.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, in_data holds valid results this cycle.
- in_data, input, [NUM_FEATURES-1:0][PRECISION-1:0], results; feature i in element i.
- in_last, input, 1, final beat of a row; flushes the partial word.
- in_ready, output, 1, upstream may advance (drives upstream ce).
- m_valid, output, 1, m_data/m_keep/m_last valid.
- m_ready, input, 1, consumer accepts the word.
- m_data, output, OUT_LANES*PRECISION, packed word.
- m_keep, output, OUT_LANES, per-lane valid mask.
- m_last, output, 1, word ends a row.
- overflow, output, 1, sticky: a word was dropped because the FIFO was full.
- fill_level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Behaviour:
- Derived constant: BEATS = OUT_LANES/NUM_FEATURES.
- Beat counter runs 0..BEATS-1.
- Packing on each in_valid:
  - in_data[i] is written to lane b*NUM_FEATURES+i, bits [lane*PRECISION +: PRECISION], where b is the beat count.
  - The corresponding keep bits are set.
- Word close: a word closes when in_valid && (b==BEATS-1 || in_last).
  - The closed word, with its keep mask and last flag (= in_last), is pushed to the FIFO in the same cycle.
  - The beat counter returns to 0.
  - The staging register and keep mask clear, so the next beat starts a fresh word.
- Partial word on in_last: keep covers only the filled lanes; unfilled data lanes are 0.
- Latency: a closing beat at edge t gives m_valid at edge t+1, as a first-word-fall-through FIFO.
- Output handshake:
  - m_valid = FIFO not empty.
  - A pop occurs on m_valid && m_ready.
  - m_data/m_keep/m_last remain stable while m_valid && !m_ready.
- in_ready:
  - Registered: in_ready = (fill_level_next + PIPE_SLACK) < FIFO_DEPTH.
  - fill_level_next accounts for the push and the pop in the current cycle.
  - Beats arriving while in_ready=0 are still accepted; upstream drains its in-flight pipeline.
- Full FIFO:
  - Push while full without a simultaneous pop: the word is dropped, overflow is set, and the FIFO is unchanged.
  - Push and pop in the same cycle while full: both take effect and the level is unchanged.
- Empty FIFO: push and pop in the same cycle is impossible, because the FIFO is first-word-fall-through and m_valid=0 when empty.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with an explicit counter so full and empty are distinguished.
- Reset values (on the cycle after rst=1):
  - beat counter 0, staging word 0, keep 0;
  - FIFO empty, fill_level 0, m_valid 0, m_data 0, m_keep 0, m_last 0;
  - overflow 0, in_ready 1.
- Reset mid-operation: any partial word and all buffered words are discarded. in_valid is ignored while rst=1.
- in_last with in_valid=0 has no effect.

Decomposition:
- Package linear_pkg holds:
  - the lane_t typedef (logic [PRECISION-1:0]);
  - the function beats_per_word(OUT_LANES, NUM_FEATURES);
  - an elaboration-time check that OUT_LANES % NUM_FEATURES == 0.
- Sub-module sync_fifo: parameterised width and depth, first-word-fall-through, with push/pop/full/empty/count.
- Storage format: the packer stores {last, keep, data} as one FIFO word.

Test Plan:
1. Defaults, m_ready=1, four in_valid beats with in_data={8'h11,8'h22},{33,44},{55,66},{77,88}, no in_last:
   - m_valid one cycle after beat 4;
   - m_data=64'h8877_6655_4433_2211, m_keep=8'hFF, m_last=0.
2. Two beats {01,02},{03,04} with in_last on the second:
   - m_data=64'h0000_0000_0403_0201, m_keep=8'h0F, m_last=1;
   - the next beat lands in lane 0.
3. m_ready=0, continuous in_valid:
   - in_ready falls when fill_level+PIPE_SLACK reaches 16, i.e. at fill_level 12;
   - the 4 in-flight words are still stored; fill_level=16; overflow=0.
4. From full with m_ready=0, push one more word:
   - overflow=1 (sticky), fill_level stays 16, head data unchanged.
   - Then raise m_ready: 16 words drain in order; a simultaneous push and pop at full keeps the level at 16.
5. Assert rst with 2 beats staged and 5 words buffered:
   - next cycle m_valid=0, fill_level=0, overflow=0, in_ready=1;
   - a following full word starts at lane 0.
6. Random m_ready (50%), 200 random beats with random in_last:
   - the scoreboard lane-by-lane packing and keep/last match with no loss;
   - overflow=0.

Source files
------------

// File: rtl/linear_pkg.sv
// Shared types and elaboration helpers for the linear output packer.
package linear_pkg;

  localparam int LANE_W = 8;

  typedef logic [LANE_W-1:0] lane_t;

  function automatic int beats_per_word(
    input int out_lanes,
    input int num_features
  );
    return out_lanes / num_features;
  endfunction

  function automatic bit lanes_divisible(
    input int out_lanes,
    input int num_features
  );
    return (num_features > 0) &&
           ((out_lanes % num_features) == 0);
  endfunction

endpackage

// File: rtl/linear_output_packer_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic                       drop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo DEPTH must be a power of two >= 4");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  // empty FIFO presents zeros rather than stale storage
  assign dout = empty ? '0 : mem[rd_ptr];

  always_comb begin
    count_next = count;
    unique case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/linear_output_packer.sv
// Packs per-beat feature results into wide words and streams them out.
module linear_output_packer
  import linear_pkg::*;
#(
  parameter int PRECISION    = 8,
  parameter int NUM_FEATURES = 2,
  parameter int OUT_LANES    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int PIPE_SLACK   = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  input  logic [NUM_FEATURES-1:0][PRECISION-1:0] in_data,
  input  logic                                   in_last,
  output logic                                   in_ready,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [OUT_LANES*PRECISION-1:0]         m_data,
  output logic [OUT_LANES-1:0]                   m_keep,
  output logic                                   m_last,
  output logic                                   overflow,
  output logic [$clog2(FIFO_DEPTH):0]            fill_level
);

  localparam int BEATS = beats_per_word(OUT_LANES, NUM_FEATURES);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW    = OUT_LANES * PRECISION;
  localparam int FW    = 1 + OUT_LANES + DW;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  if (!lanes_divisible(OUT_LANES, NUM_FEATURES)) begin : g_bad_cfg
    $error("OUT_LANES must be a multiple of NUM_FEATURES");
  end

  logic [BW-1:0]        beat;
  logic [DW-1:0]        stage_data;
  logic [OUT_LANES-1:0] stage_keep;
  logic [DW-1:0]        word_data;
  logic [OUT_LANES-1:0] word_keep;
  logic                 closing;
  logic                 pop;
  logic                 empty;
  logic                 full;
  logic                 drop;
  logic [FW-1:0]        fifo_din;
  logic [FW-1:0]        fifo_dout;
  logic [CW-1:0]        count_next;

  always_comb begin
    word_data = stage_data;
    word_keep = stage_keep;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      word_data[(int'(beat) * NUM_FEATURES + i) * PRECISION +: PRECISION]
        = in_data[i];
      word_keep[int'(beat) * NUM_FEATURES + i] = 1'b1;
    end
  end

  assign closing = in_valid &&
                   ((beat == BW'(BEATS - 1)) || in_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat       <= '0;
      stage_data <= '0;
      stage_keep <= '0;
    end else if (in_valid) begin
      if (closing) begin
        beat       <= '0;
        stage_data <= '0;
        stage_keep <= '0;
      end else begin
        beat       <= beat + BW'(1);
        stage_data <= word_data;
        stage_keep <= word_keep;
      end
    end
  end

  assign fifo_din = {in_last, word_keep, word_data};
  assign pop      = m_valid && m_ready;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (closing),
    .pop        (pop),
    .din        (fifo_din),
    .dout       (fifo_dout),
    .full       (full),
    .empty      (empty),
    .drop       (drop),
    .count      (fill_level),
    .count_next (count_next)
  );

  assign m_valid = !empty;
  assign m_data  = fifo_dout[DW-1:0];
  assign m_keep  = fifo_dout[DW +: OUT_LANES];
  assign m_last  = fifo_dout[FW-1];

  // in_ready leads the FIFO by PIPE_SLACK words still in flight upstream
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      if (drop) overflow <= 1'b1;
      in_ready <= (int'(count_next) + PIPE_SLACK) < FIFO_DEPTH;
    end
  end

endmodule

// File: tb/tb_linear_output_packer.sv
// Directed and scoreboarded bench for linear_output_packer.
module tb_linear_output_packer;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [1:0][7:0] in_data = '0;
  logic            in_last = 1'b0;
  logic            in_ready;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [63:0]     m_data;
  logic [7:0]      m_keep;
  logic            m_last;
  logic            overflow;
  logic [4:0]      fill_level;

  int n_checks = 0;
  int n_fail = 0;

  logic [72:0] exp_q[$];
  logic [63:0] mdl_data = '0;
  logic [7:0]  mdl_keep = '0;
  int          mdl_beat = 0;
  bit          expect_drop = 1'b0;

  always #5 clk = ~clk;

  linear_output_packer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_last     (m_last),
    .overflow   (overflow),
    .fill_level (fill_level)
  );

  task automatic check(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_clear();
    mdl_data = '0;
    mdl_keep = '0;
    mdl_beat = 0;
    exp_q.delete();
  endtask

  task automatic beat(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       last
  );
    in_valid   = 1'b1;
    in_data[0] = a;
    in_data[1] = b;
    in_last    = last;
    mdl_data[mdl_beat*16 +: 8]     = a;
    mdl_data[mdl_beat*16 + 8 +: 8] = b;
    mdl_keep[mdl_beat*2 +: 2]      = 2'b11;
    if (mdl_beat == 3 || last) begin
      if (!expect_drop) exp_q.push_back({last, mdl_keep, mdl_data});
      mdl_data = '0;
      mdl_keep = '0;
      mdl_beat = 0;
    end else begin
      mdl_beat++;
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_word(input int k);
    for (int j = 0; j < 4; j++)
      beat(8'(k*8 + j*2), 8'(k*8 + j*2 + 1), 1'b0);
  endtask

  task automatic wait_empty(input string tag);
    for (int c = 0; c < 64 && fill_level != 0; c++) tick();
    check(tag, 128'(fill_level), 128'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_spurious", 128'd1, 128'd0);
      end else begin
        logic [72:0] w;
        w = exp_q.pop_front();
        check("sb_data", 128'(m_data), 128'(w[63:0]));
        check("sb_keep", 128'(m_keep), 128'(w[71:64]));
        check("sb_last", 128'(m_last), 128'(w[72]));
      end
    end
  end

  initial begin
    logic [63:0] head;
    int          cnt;
    int          sent;
    int          cyc;

    tick();
    tick();
    rst = 1'b0;
    check("rst_m_valid", 128'(m_valid), 128'd0);
    check("rst_fill", 128'(fill_level), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_overflow", 128'(overflow), 128'd0);
    check("rst_m_data", 128'(m_data), 128'd0);
    check("rst_m_keep", 128'(m_keep), 128'd0);
    check("rst_m_last", 128'(m_last), 128'd0);

    // full word
    m_ready = 1'b1;
    beat(8'h11, 8'h22, 1'b0);
    beat(8'h33, 8'h44, 1'b0);
    beat(8'h55, 8'h66, 1'b0);
    check("t1_no_valid_early", 128'(m_valid), 128'd0);
    beat(8'h77, 8'h88, 1'b0);
    check("t1_m_valid", 128'(m_valid), 128'd1);
    check("t1_m_data", 128'(m_data), 128'h8877_6655_4433_2211);
    check("t1_m_keep", 128'(m_keep), 128'hFF);
    check("t1_m_last", 128'(m_last), 128'd0);
    tick();
    check("t1_popped", 128'(m_valid), 128'd0);

    // partial word flushed by in_last
    beat(8'h01, 8'h02, 1'b0);
    beat(8'h03, 8'h04, 1'b1);
    check("t2_m_data", 128'(m_data), 128'h0000_0000_0403_0201);
    check("t2_m_keep", 128'(m_keep), 128'h0F);
    check("t2_m_last", 128'(m_last), 128'd1);
    tick();
    beat(8'hA0, 8'hA1, 1'b0);
    beat(8'hA2, 8'hA3, 1'b0);
    beat(8'hA4, 8'hA5, 1'b0);
    beat(8'hA6, 8'hA7, 1'b0);
    check("t2_next_lane0", 128'(m_data), 128'hA7A6_A5A4_A3A2_A1A0);
    wait_empty("t2_drain");

    // fill up against a stalled consumer
    m_ready = 1'b0;
    cnt = 0;
    while (in_ready && cnt < 20) begin
      send_word(cnt);
      cnt++;
    end
    check("t3_words_before_stall", 128'(cnt), 128'd12);
    check("t3_fill_at_stall", 128'(fill_level), 128'd12);
    check("t3_in_ready_low", 128'(in_ready), 128'd0);
    for (int k = 0; k < 4; k++) send_word(cnt + k);
    check("t3_fill_full", 128'(fill_level), 128'd16);
    check("t3_overflow", 128'(overflow), 128'd0);

    // overflow, then push and pop at full
    head = exp_q[0][63:0];
    expect_drop = 1'b1;
    send_word(40);
    expect_drop = 1'b0;
    check("t4_overflow", 128'(overflow), 128'd1);
    check("t4_fill", 128'(fill_level), 128'd16);
    check("t4_head", 128'(m_data), 128'(head));
    beat(8'hC0, 8'hC1, 1'b0);
    beat(8'hC2, 8'hC3, 1'b0);
    beat(8'hC4, 8'hC5, 1'b0);
    m_ready = 1'b1;
    beat(8'hC6, 8'hC7, 1'b0);
    check("t4_fill_push_pop", 128'(fill_level), 128'd16);
    wait_empty("t4_drain");
    check("t4_sb_left", 128'(exp_q.size()), 128'd0);
    check("t4_overflow_sticky", 128'(overflow), 128'd1);

    // reset mid-operation
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_word(50 + k);
    beat(8'hE0, 8'hE1, 1'b0);
    beat(8'hE2, 8'hE3, 1'b0);
    check("t5_fill_pre", 128'(fill_level), 128'd5);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data[0] = 8'hEE;
    in_data[1] = 8'hEF;
    mdl_clear();
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("t5_m_valid", 128'(m_valid), 128'd0);
    check("t5_fill", 128'(fill_level), 128'd0);
    check("t5_overflow", 128'(overflow), 128'd0);
    check("t5_in_ready", 128'(in_ready), 128'd1);
    m_ready = 1'b1;
    beat(8'hD0, 8'hD1, 1'b0);
    beat(8'hD2, 8'hD3, 1'b0);
    beat(8'hD4, 8'hD5, 1'b0);
    beat(8'hD6, 8'hD7, 1'b0);
    check("t5_lane0", 128'(m_data), 128'hD7D6_D5D4_D3D2_D1D0);
    check("t5_keep", 128'(m_keep), 128'hFF);
    wait_empty("t5_drain");

    // random backpressure with in_ready-gated source
    sent = 0;
    cyc = 0;
    while (sent < 200 && cyc < 4000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (in_ready) begin
        beat(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
        sent++;
      end else begin
        tick();
      end
      cyc++;
    end
    check("t6_sent", 128'(sent), 128'd200);
    m_ready = 1'b1;
    wait_empty("t6_drain");
    tick();
    check("t6_sb_left", 128'(exp_q.size()), 128'd0);
    check("t6_overflow", 128'(overflow), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
